// File: rtl/uart_alim_birimi_pkg.sv
// Shared constants for the UART receive path: FSM encodings, baud limit,
// and the 3-sample majority helper.
package uart_alim_birimi_pkg;

   localparam logic [1:0] UART_RX_BOSTA = 2'd0;
   localparam logic [1:0] UART_RX_BASLA = 2'd1;
   localparam logic [1:0] UART_RX_VERI  = 2'd2;
   localparam logic [1:0] UART_RX_DUR   = 2'd3;

   localparam logic [15:0] UART_MIN_BAUD_DIV = 16'd8;

   function automatic logic cogunluk(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_alim_birimi_senkronlayici.sv
// Flip-flop synchroniser for an asynchronous input; resets to the idle-high
// level so a line held high never produces a spurious edge out of reset.
module senkronlayici #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] zincir_r;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) zincir_r <= '1;
      else         zincir_r <= {zincir_r[SYNC_STAGES-2:0], d_i};
   end

   assign q_o = zincir_r[SYNC_STAGES-1];

endmodule

// File: rtl/uart_alim_birimi.sv
// 8N1 serial receive engine: start qualification, 3-sample majority voting at
// bit centre, and a one-entry valid/ready holding register for the RX FIFO.
module uart_alim_birimi
   import uart_alim_birimi_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_BIT    = 8
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                rx_en_i,
   input  logic [15:0]         baud_div_i,
   input  logic                rx_i,
   output logic [DATA_BIT-1:0] veri_o,
   output logic                veri_gecerli_o,
   input  logic                veri_hazir_i,
   output logic                cerceve_hata_o,
   output logic                tasma_hata_o,
   output logic                mesgul_o
);

   localparam int BW = $clog2(DATA_BIT + 2);

   logic                rx_s, rx_d;
   logic [1:0]          durum_r;
   logic [15:0]         div_r, sayac, yari;
   logic [BW-1:0]       bit_r;
   logic                ornek0, ornek1;
   logic [DATA_BIT-1:0] kaydir_r;
   logic                sarma, karar, oy, baslangic, dur_karar;

   senkronlayici #(.SYNC_STAGES(SYNC_STAGES)) u_senk (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .d_i    (rx_i),
      .q_o    (rx_s)
   );

   assign yari      = div_r >> 1;
   assign sarma     = (sayac == div_r - 16'd1);
   assign karar     = (sayac == yari + 16'd1);
   // Third sample is the live line value, so the vote resolves at yari+1.
   assign oy        = cogunluk(ornek0, ornek1, rx_s);
   assign baslangic = rx_en_i && rx_d && !rx_s;
   assign dur_karar = (durum_r == UART_RX_DUR) && rx_en_i && karar;
   assign mesgul_o  = (durum_r != UART_RX_BOSTA);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rx_d     <= 1'b1;
         durum_r  <= UART_RX_BOSTA;
         div_r    <= UART_MIN_BAUD_DIV;
         sayac    <= '0;
         bit_r    <= '0;
         ornek0   <= 1'b1;
         ornek1   <= 1'b1;
         kaydir_r <= '0;
      end else begin
         rx_d <= rx_s;
         if (durum_r == UART_RX_BOSTA) begin
            if (baslangic) begin
               div_r   <= baud_div_i;
               sayac   <= '0;
               bit_r   <= '0;
               durum_r <= UART_RX_BASLA;
            end
         end else if (!rx_en_i) begin
            durum_r <= UART_RX_BOSTA;
         end else begin
            sayac <= sarma ? 16'd0 : sayac + 16'd1;
            if (sarma) bit_r <= bit_r + BW'(1);
            if (sayac == yari - 16'd1) ornek0 <= rx_s;
            if (sayac == yari)         ornek1 <= rx_s;
            case (durum_r)
               UART_RX_BASLA: begin
                  if (karar && oy)  durum_r <= UART_RX_BOSTA;
                  else if (sarma)   durum_r <= UART_RX_VERI;
               end
               UART_RX_VERI: begin
                  if (karar) kaydir_r <= {oy, kaydir_r[DATA_BIT-1:1]};
                  if (sarma && bit_r == BW'(DATA_BIT)) durum_r <= UART_RX_DUR;
               end
               // Leave mid-stop-bit so a back-to-back start edge is not missed.
               UART_RX_DUR: if (karar) durum_r <= UART_RX_BOSTA;
               default:     durum_r <= UART_RX_BOSTA;
            endcase
         end
      end
   end

   // Acceptance and a new load on the same cycle keep valid high with the new byte.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         veri_o         <= '0;
         veri_gecerli_o <= 1'b0;
         cerceve_hata_o <= 1'b0;
         tasma_hata_o   <= 1'b0;
      end else begin
         cerceve_hata_o <= 1'b0;
         tasma_hata_o   <= 1'b0;
         if (veri_gecerli_o && veri_hazir_i) veri_gecerli_o <= 1'b0;
         if (dur_karar) begin
            if (!oy)
               cerceve_hata_o <= 1'b1;
            else if (veri_gecerli_o && !veri_hazir_i)
               tasma_hata_o <= 1'b1;
            else begin
               veri_o         <= kaydir_r;
               veri_gecerli_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_alim_birimi.sv
// Directed bench for uart_alim_birimi: latency, glitch/noise, framing,
// overrun, streaming and abort paths.
module tb_uart_alim_birimi;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        rx_en_i;
   logic [15:0] baud_div_i;
   logic        rx_i;
   logic [7:0]  veri_o;
   logic        veri_gecerli_o;
   logic        veri_hazir_i;
   logic        cerceve_hata_o;
   logic        tasma_hata_o;
   logic        mesgul_o;

   int n_chk = 0;
   int n_ok  = 0;
   int cer_n = 0;
   int tas_n = 0;
   logic [7:0] rxq[$];
   bit abort_tx = 1'b0;

   always #5 clk_i = ~clk_i;

   uart_alim_birimi #(.SYNC_STAGES(2), .DATA_BIT(8)) dut (
      .clk_i          (clk_i),
      .rstn_i         (rstn_i),
      .rx_en_i        (rx_en_i),
      .baud_div_i     (baud_div_i),
      .rx_i           (rx_i),
      .veri_o         (veri_o),
      .veri_gecerli_o (veri_gecerli_o),
      .veri_hazir_i   (veri_hazir_i),
      .cerceve_hata_o (cerceve_hata_o),
      .tasma_hata_o   (tasma_hata_o),
      .mesgul_o       (mesgul_o)
   );

   // Accepted bytes and error pulses, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (rstn_i) begin
         if (veri_gecerli_o && veri_hazir_i) rxq.push_back(veri_o);
         if (cerceve_hata_o) cer_n++;
         if (tasma_hata_o)   tas_n++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_ok++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   // Drives one frame from a negedge; spike inverts one cycle at the centre of frame bit 'spike'.
   task automatic send_frame(input logic [7:0] b, input logic stp, input int div, input int spike);
      logic [9:0] f;
      f = {stp, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < div; c++) begin
            if (abort_tx) begin
               rx_i = 1'b1;
               return;
            end
            rx_i = (i == spike && c == div / 2) ? ~f[i] : f[i];
            @(negedge clk_i);
         end
      end
      rx_i = 1'b1;
   endtask

   initial begin
      int first, base, cbase, tbase;
      logic [7:0] v_at_first;
      logic v_next;

      rstn_i = 1'b0; rx_en_i = 1'b1; baud_div_i = 16'd16; rx_i = 1'b1; veri_hazir_i = 1'b1;
      idle(3);
      chk("rst_veri",    veri_o, 8'h00);
      chk("rst_gecerli", veri_gecerli_o, 1'b0);
      chk("rst_cerceve", cerceve_hata_o, 1'b0);
      chk("rst_tasma",   tas_n + tasma_hata_o, 0);
      chk("rst_mesgul",  mesgul_o, 1'b0);
      rstn_i = 1'b1;
      idle(5);

      // Single frame: first valid at edge 2 + 9*16 + 8 + 2 = 156.
      first = -1; v_at_first = 8'h00; v_next = 1'b1; base = rxq.size();
      fork
         send_frame(8'hA5, 1'b1, 16, -1);
         begin
            for (int k = 0; k < 200; k++) begin
               @(posedge clk_i); #1;
               if (first < 0 && veri_gecerli_o) begin
                  first = k; v_at_first = veri_o;
               end else if (first >= 0 && k == first + 1) v_next = veri_gecerli_o;
            end
         end
      join
      chk("lat_edge",   first, 156);
      chk("lat_veri",   v_at_first, 8'hA5);
      chk("lat_1cyc",   v_next, 1'b0);
      chk("lat_count",  rxq.size() - base, 1);
      idle(10);

      // 3-cycle glitch is rejected.
      base = rxq.size(); cbase = cer_n; tbase = tas_n;
      rx_i = 1'b0; idle(3); rx_i = 1'b1;
      chk("glitch_busy", mesgul_o, 1'b1);
      idle(40);
      chk("glitch_idle",  mesgul_o, 1'b0);
      chk("glitch_nodat", rxq.size() - base, 0);
      chk("glitch_noerr", (cer_n - cbase) + (tas_n - tbase), 0);

      // One-cycle spike at a data-bit centre is voted out.
      base = rxq.size();
      send_frame(8'h5A, 1'b1, 16, 4);
      idle(20);
      chk("spike_cnt", rxq.size() - base, 1);
      if (rxq.size() > base) chk("spike_veri", rxq[base], 8'h5A);

      // Framing error, then a clean frame.
      base = rxq.size(); cbase = cer_n;
      send_frame(8'h3C, 1'b0, 16, -1);
      idle(20);
      chk("frm_pulse",  cer_n - cbase, 1);
      chk("frm_nodat",  rxq.size() - base, 0);
      send_frame(8'h81, 1'b1, 16, -1);
      idle(20);
      chk("frm_next_cnt", rxq.size() - base, 1);
      if (rxq.size() > base) chk("frm_next_veri", rxq[base], 8'h81);

      // Overrun: second byte dropped, first held.
      veri_hazir_i = 1'b0; base = rxq.size(); tbase = tas_n;
      send_frame(8'h11, 1'b1, 16, -1);
      send_frame(8'h22, 1'b1, 16, -1);
      idle(20);
      chk("ovr_pulse", tas_n - tbase, 1);
      chk("ovr_valid", veri_gecerli_o, 1'b1);
      chk("ovr_held",  veri_o, 8'h11);
      veri_hazir_i = 1'b1;
      idle(2);
      chk("ovr_clear", veri_gecerli_o, 1'b0);
      chk("ovr_cnt",   rxq.size() - base, 1);
      if (rxq.size() > base) chk("ovr_veri", rxq[base], 8'h11);

      // Streaming at div 10.
      baud_div_i = 16'd10; base = rxq.size(); cbase = cer_n; tbase = tas_n;
      send_frame(8'h00, 1'b1, 10, -1);
      send_frame(8'hFF, 1'b1, 10, -1);
      send_frame(8'h55, 1'b1, 10, -1);
      send_frame(8'hAA, 1'b1, 10, -1);
      idle(20);
      chk("str_cnt",   rxq.size() - base, 4);
      chk("str_noerr", (cer_n - cbase) + (tas_n - tbase), 0);
      if (rxq.size() >= base + 4) begin
         chk("str_b0", rxq[base],     8'h00);
         chk("str_b1", rxq[base + 1], 8'hFF);
         chk("str_b2", rxq[base + 2], 8'h55);
         chk("str_b3", rxq[base + 3], 8'hAA);
      end

      // rx_en_i dropped during data bit 3.
      baud_div_i = 16'd16; base = rxq.size(); cbase = cer_n; tbase = tas_n;
      fork
         send_frame(8'hC3, 1'b1, 16, -1);
         begin
            idle(4 * 16 + 8);
            rx_en_i = 1'b0;
            @(posedge clk_i); #1;
            chk("abt_idle", mesgul_o, 1'b0);
         end
      join
      idle(20);
      rx_en_i = 1'b1;
      idle(20);
      chk("abt_nodat",  rxq.size() - base, 0);
      chk("abt_noerr",  (cer_n - cbase) + (tas_n - tbase), 0);

      // Reset mid-frame with a byte held, then a clean frame.
      veri_hazir_i = 1'b0;
      send_frame(8'h33, 1'b1, 16, -1);
      idle(20);
      chk("rstm_held", veri_gecerli_o, 1'b1);
      fork
         send_frame(8'h44, 1'b1, 16, -1);
         begin
            idle(50);
            rstn_i = 1'b0; #1;
            chk("rstm_veri",   veri_o, 8'h00);
            chk("rstm_valid",  veri_gecerli_o, 1'b0);
            chk("rstm_mesgul", mesgul_o, 1'b0);
            abort_tx = 1'b1;
            idle(2);
            rstn_i = 1'b1;
         end
      join
      abort_tx = 1'b0; veri_hazir_i = 1'b1; base = rxq.size();
      idle(20);
      send_frame(8'h7E, 1'b1, 16, -1);
      idle(20);
      chk("rstm_cnt", rxq.size() - base, 1);
      if (rxq.size() > base) chk("rstm_next", rxq[base], 8'h7E);

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

endmodule
